// File: rtl/wildcmp_pipe.sv
// ============================================================================
// Module   : wildcmp_pipe
// Brief    : Two-stage wildcard comparator. Each operand is extended to W
//            bits and compared against DEPTH (pattern, mask) entries. A mask
//            bit of 1 makes that pattern bit a don't-care. The result is a
//            per-entry inequality vector plus a lowest-matching-index
//            summary, delivered over a valid/ready handshake.
// Options  : WILDCMP_HIT_CNT_EN adds per-entry 8-bit saturating hit counters
//            and the hit_sel / hit_cnt ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wildcmp_pipe #(
    parameter int IN_W   = 9,
    parameter int W      = 16,
    parameter int DEPTH  = 4,
    parameter int SIGNED = 0,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [W-1:0]     cfg_pat,
    input  logic [W-1:0]     cfg_mask,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DEPTH-1:0] out_neq,
    output logic             out_any_eq,
    output logic [IW-1:0]    out_idx
`ifdef WILDCMP_HIT_CNT_EN
    ,
    input  logic [IW-1:0]    hit_sel,
    output logic [7:0]       hit_cnt
`endif
);

    // Operand must fit in the compare width; the table needs two entries.
    generate
        if (IN_W > W || DEPTH < 2) begin : g_param_check
            $fatal(1, "wildcmp_pipe: requires IN_W <= W and DEPTH >= 2");
        end
    endgenerate

    logic [W-1:0]     r_pat  [DEPTH];
    logic [W-1:0]     r_mask [DEPTH];
    logic [W-1:0]     w_ext;
    logic [DEPTH-1:0] w_neq;
    logic             w_idx_ok;
    logic             w_s2_adv;
    logic             r_s1_valid;
    logic [DEPTH-1:0] r_s1_neq;
    logic [IW-1:0]    w_low_idx;

    assign w_ext    = (SIGNED != 0) ? W'($signed(in_data)) : W'(in_data);
    assign w_idx_ok = int'(cfg_idx) < DEPTH;

    // Output stage can take new data when empty or being drained this cycle.
    assign w_s2_adv = !out_valid || out_ready;
    assign in_ready = !r_s1_valid || w_s2_adv;

    // Pattern table; stage 1 reads the registered copy, so a same-cycle
    // write is only seen by operands accepted afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pat[i]  <= '0;
                r_mask[i] <= '0;
            end
        end else if (cfg_we && w_idx_ok) begin
            r_pat[cfg_idx]  <= cfg_pat;
            r_mask[cfg_idx] <= cfg_mask;
        end
    end

    // Per-entry wildcard inequality of the incoming operand.
    always_comb begin
        w_neq = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_neq[i] = |((w_ext ^ r_pat[i]) & ~r_mask[i]);
        end
    end

    // Stage 1: capture the inequality vector on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_neq   <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_neq <= w_neq;
            end
        end
    end

    // Lowest index whose entry matched; scanning downward leaves the lowest.
    always_comb begin
        w_low_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_s1_neq[i]) begin
                w_low_idx = IW'(i);
            end
        end
    end

    // Stage 2: result register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_neq    <= '0;
            out_any_eq <= 1'b0;
            out_idx    <= '0;
        end else if (w_s2_adv) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_neq    <= r_s1_neq;
                out_any_eq <= ~&r_s1_neq;
                out_idx    <= w_low_idx;
            end
        end
    end

`ifdef WILDCMP_HIT_CNT_EN
    logic [7:0] r_hit [DEPTH];
    logic       w_hit;

    assign w_hit   = out_valid && out_ready && out_any_eq;
    assign hit_cnt = (int'(hit_sel) < DEPTH) ? r_hit[hit_sel] : 8'd0;

    // Saturating hit counters; rewriting an entry restarts its count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hit[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cfg_we && w_idx_ok && int'(cfg_idx) == i) begin
                    r_hit[i] <= 8'd0;
                end else if (w_hit && int'(out_idx) == i && r_hit[i] != 8'hFF) begin
                    r_hit[i] <= r_hit[i] + 8'd1;
                end
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wildcmp_pipe.sv
// ============================================================================
// Module   : tb_wildcmp_pipe
// Brief    : Directed self-checking bench for wildcmp_pipe (W=16, IN_W=9,
//            DEPTH=4). An unsigned and a signed instance share all inputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wildcmp_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [15:0] cfg_pat;
    logic [15:0] cfg_mask;
    logic        in_valid;
    logic [8:0]  in_data;
    logic        out_ready;

    logic        in_ready_u, out_valid_u, any_u;
    logic [3:0]  neq_u;
    logic [1:0]  idx_u;
    logic        in_ready_s, out_valid_s, any_s;
    logic [3:0]  neq_s;
    logic [1:0]  idx_s;
`ifdef WILDCMP_HIT_CNT_EN
    logic [1:0]  hit_sel;
    logic [7:0]  hit_cnt_u, hit_cnt_s;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wildcmp_pipe #(.IN_W(9), .W(16), .DEPTH(4), .SIGNED(0)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_pat(cfg_pat), .cfg_mask(cfg_mask), .in_valid(in_valid),
        .in_ready(in_ready_u), .in_data(in_data), .out_valid(out_valid_u),
        .out_ready(out_ready), .out_neq(neq_u), .out_any_eq(any_u),
        .out_idx(idx_u)
`ifdef WILDCMP_HIT_CNT_EN
        , .hit_sel(hit_sel), .hit_cnt(hit_cnt_u)
`endif
    );

    wildcmp_pipe #(.IN_W(9), .W(16), .DEPTH(4), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_pat(cfg_pat), .cfg_mask(cfg_mask), .in_valid(in_valid),
        .in_ready(in_ready_s), .in_data(in_data), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_neq(neq_s), .out_any_eq(any_s),
        .out_idx(idx_s)
`ifdef WILDCMP_HIT_CNT_EN
        , .hit_sel(hit_sel), .hit_cnt(hit_cnt_s)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [15:0] pat,
                             input logic [15:0] mask);
        cfg_we = 1'b1; cfg_idx = idx; cfg_pat = pat; cfg_mask = mask;
        tick();
        cfg_we = 1'b0;
    endtask

    // One operand through an idle, unstalled pipe; returns what appeared
    // one edge after acceptance and the result seen after the second edge.
    task automatic send_one(input logic [8:0] d, output logic early,
                            output logic vu, output logic [3:0] nu, output logic au,
                            output logic [1:0] iu, output logic vs,
                            output logic [3:0] ns, output logic as_, output logic [1:0] is_);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
        early = out_valid_u;
        tick();
        vu = out_valid_u; nu = neq_u; au = any_u; iu = idx_u;
        vs = out_valid_s; ns = neq_s; as_ = any_s; is_ = idx_s;
        tick();
    endtask

    task automatic test_reset();
        logic e, vu, au, vs, as_;
        logic [3:0] nu, ns;
        logic [1:0] iu, is_;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_pat = '0; cfg_mask = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) tick();
        checks++; if (out_valid_u !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_u); end
        checks++; if (neq_u !== 4'h0) begin failures++; $display("FAIL reset_out_neq got=%h exp=0", neq_u); end
        checks++; if (any_u !== 1'b0 || idx_u !== 2'd0) begin failures++; $display("FAIL reset_any_idx got=%b/%0d exp=0/0", any_u, idx_u); end
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready_u !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_u); end
        // Cleared table: zero matches everything, one matches nothing.
        send_one(9'h000, e, vu, nu, au, iu, vs, ns, as_, is_);
        checks++; if (vu !== 1'b1 || nu !== 4'h0 || au !== 1'b1 || iu !== 2'd0) begin failures++; $display("FAIL reset_tbl_zero got=%b/%h/%b/%0d exp=1/0/1/0", vu, nu, au, iu); end
        send_one(9'h001, e, vu, nu, au, iu, vs, ns, as_, is_);
        checks++; if (vu !== 1'b1 || nu !== 4'hF || au !== 1'b0 || iu !== 2'd0) begin failures++; $display("FAIL reset_tbl_one got=%b/%h/%b/%0d exp=1/F/0/0", vu, nu, au, iu); end
    endtask

    task automatic test_signed();
        logic e, vu, au, vs, as_;
        logic [3:0] nu, ns;
        logic [1:0] iu, is_;
        cfg_write(2'd0, 16'hFFFF, 16'h0000);
        send_one(9'h1FF, e, vu, nu, au, iu, vs, ns, as_, is_);
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", e); end
        checks++; if (vs !== 1'b1 || ns !== 4'b1110 || as_ !== 1'b1 || is_ !== 2'd0) begin failures++; $display("FAIL signed_ext got=%b/%h/%b/%0d exp=1/E/1/0", vs, ns, as_, is_); end
        checks++; if (vu !== 1'b1 || nu !== 4'b1111 || au !== 1'b0 || iu !== 2'd0) begin failures++; $display("FAIL unsigned_ext got=%b/%h/%b/%0d exp=1/F/0/0", vu, nu, au, iu); end
    endtask

    task automatic test_unsigned_mask();
        logic e, vu, au, vs, as_;
        logic [3:0] nu, ns;
        logic [1:0] iu, is_;
        cfg_write(2'd2, 16'h0100, 16'h00FF);
        send_one(9'h1FF, e, vu, nu, au, iu, vs, ns, as_, is_);
        checks++; if (nu !== 4'b1011 || au !== 1'b1 || iu !== 2'd2) begin failures++; $display("FAIL unsigned_idx2 got=%h/%b/%0d exp=B/1/2", nu, au, iu); end
        checks++; if (ns !== 4'b1110 || is_ !== 2'd0) begin failures++; $display("FAIL signed_idx0 got=%h/%0d exp=E/0", ns, is_); end
        // All-ones mask makes entry 1 match any operand.
        cfg_write(2'd1, 16'h1234, 16'hFFFF);
        send_one(9'h0AA, e, vu, nu, au, iu, vs, ns, as_, is_);
        checks++; if (nu !== 4'b1101 || au !== 1'b1 || iu !== 2'd1) begin failures++; $display("FAIL full_mask got=%h/%b/%0d exp=D/1/1", nu, au, iu); end
        checks++; if (ns !== 4'b1101 || is_ !== 2'd1) begin failures++; $display("FAIL full_mask_s got=%h/%0d exp=D/1", ns, is_); end
    endtask

    task automatic test_write_same_cycle();
        logic e, vu, au, vs, as_;
        logic [3:0] nu, ns;
        logic [1:0] iu, is_;
        cfg_write(2'd1, 16'h0000, 16'h0000);
        out_ready = 1'b1;
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_pat = 16'h0005; cfg_mask = 16'h0000;
        in_valid = 1'b1; in_data = 9'h005;
        tick();
        cfg_we = 1'b0; in_valid = 1'b0;
        tick();
        checks++; if (out_valid_u !== 1'b1 || neq_u !== 4'hF || any_u !== 1'b0) begin failures++; $display("FAIL wr_same_cycle got=%b/%h/%b exp=1/F/0", out_valid_u, neq_u, any_u); end
        tick();
        send_one(9'h005, e, vu, nu, au, iu, vs, ns, as_, is_);
        checks++; if (nu !== 4'b1101 || au !== 1'b1 || iu !== 2'd1) begin failures++; $display("FAIL wr_next_op got=%h/%b/%0d exp=D/1/1", nu, au, iu); end
    endtask

    task automatic test_stall();
        logic [8:0] d [3];
        logic [3:0] en [3];
        logic [1:0] ei [3];
        int n_acc, got;
        logic acc;
        d[0] = 9'h005; en[0] = 4'b1101; ei[0] = 2'd1;
        d[1] = 9'h1FF; en[1] = 4'b1011; ei[1] = 2'd2;
        d[2] = 9'h000; en[2] = 4'b0111; ei[2] = 2'd3;
        n_acc = 0; got = 0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = d[0];
        for (int c = 0; c < 5; c++) begin
            acc = in_valid && in_ready_u;
            tick();
            if (acc) begin
                n_acc++;
                if (n_acc < 3) in_data = d[n_acc]; else in_valid = 1'b0;
            end
            if (c == 2) begin
                checks++; if (out_valid_u !== 1'b1 || neq_u !== en[0] || idx_u !== ei[0]) begin failures++; $display("FAIL stall_hold_mid got=%b/%h/%0d exp=1/%h/%0d", out_valid_u, neq_u, idx_u, en[0], ei[0]); end
            end
        end
        checks++; if (n_acc != 2 || in_ready_u !== 1'b0) begin failures++; $display("FAIL stall_backpressure got=acc%0d/rdy%b exp=acc2/rdy0", n_acc, in_ready_u); end
        checks++; if (out_valid_u !== 1'b1 || neq_u !== en[0] || idx_u !== ei[0]) begin failures++; $display("FAIL stall_hold_end got=%b/%h/%0d exp=1/%h/%0d", out_valid_u, neq_u, idx_u, en[0], ei[0]); end
        out_ready = 1'b1;
        for (int c = 0; c < 12 && got < 3; c++) begin
            if (out_valid_u) begin
                checks++; if (neq_u !== en[got] || idx_u !== ei[got]) begin failures++; $display("FAIL stall_order_%0d got=%h/%0d exp=%h/%0d", got, neq_u, idx_u, en[got], ei[got]); end
                got++;
            end
            acc = in_valid && in_ready_u;
            tick();
            if (acc) begin
                n_acc++;
                if (n_acc < 3) in_data = d[n_acc]; else in_valid = 1'b0;
            end
        end
        checks++; if (got != 3) begin failures++; $display("FAIL stall_count got=%0d exp=3", got); end
        tick();
        checks++; if (out_valid_u !== 1'b0) begin failures++; $display("FAIL stall_dup got=%b exp=0", out_valid_u); end
    endtask

    task automatic test_reset_flight();
        logic e, vu, au, vs, as_;
        logic [3:0] nu, ns;
        logic [1:0] iu, is_;
        int emitted;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 9'h000;
        tick();
        in_data = 9'h005;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid_u !== 1'b0) begin failures++; $display("FAIL rst_flight_valid got=%b exp=0", out_valid_u); end
        tick();
        rst_n = 1'b1;
        emitted = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (out_valid_u) emitted++;
        end
        checks++; if (emitted != 0) begin failures++; $display("FAIL rst_flight_emit got=%0d exp=0", emitted); end
        send_one(9'h000, e, vu, nu, au, iu, vs, ns, as_, is_);
        checks++; if (nu !== 4'h0 || au !== 1'b1 || iu !== 2'd0) begin failures++; $display("FAIL rst_flight_table got=%h/%b/%0d exp=0/1/0", nu, au, iu); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] d [3];
        logic [3:0] en [3];
        int got, first, last;
        d[0] = 9'h000; en[0] = 4'h0;
        d[1] = 9'h001; en[1] = 4'hF;
        d[2] = 9'h000; en[2] = 4'h0;
        got = 0; first = -1; last = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid_u && got < 3) begin
                checks++; if (neq_u !== en[got]) begin failures++; $display("FAIL b2b_%0d got=%h exp=%h", got, neq_u, en[got]); end
                if (first < 0) first = c;
                last = c;
                got++;
            end
            in_valid = (c < 3);
            if (c < 3) in_data = d[c];
            tick();
        end
        in_valid = 1'b0;
        checks++; if (got != 3 || first != 2 || last != 4) begin failures++; $display("FAIL b2b_rate got=%0d/%0d..%0d exp=3/2..4", got, first, last); end
    endtask

`ifdef WILDCMP_HIT_CNT_EN
    task automatic test_hit_cnt();
        cfg_write(2'd0, 16'hFFFF, 16'h0000);
        cfg_write(2'd1, 16'hFFFF, 16'h0000);
        cfg_write(2'd2, 16'hFFFF, 16'h0000);
        cfg_write(2'd3, 16'h0000, 16'hFFFF);
        hit_sel = 2'd3; out_ready = 1'b1;
        #1;
        checks++; if (hit_cnt_u !== 8'd0) begin failures++; $display("FAIL hit_start got=%0d exp=0", hit_cnt_u); end
        in_valid = 1'b1; in_data = 9'h000;
        repeat (300) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        checks++; if (hit_cnt_u !== 8'd255) begin failures++; $display("FAIL hit_sat got=%0d exp=255", hit_cnt_u); end
        hit_sel = 2'd0;
        #1;
        checks++; if (hit_cnt_u !== 8'd0) begin failures++; $display("FAIL hit_other got=%0d exp=0", hit_cnt_u); end
        hit_sel = 2'd3;
        cfg_write(2'd3, 16'h0000, 16'hFFFF);
        checks++; if (hit_cnt_u !== 8'd0) begin failures++; $display("FAIL hit_clear got=%0d exp=0", hit_cnt_u); end
    endtask
`endif

    initial begin
`ifdef WILDCMP_HIT_CNT_EN
        hit_sel = 2'd0;
`endif
        test_reset();
        test_signed();
        test_unsigned_mask();
        test_write_same_cycle();
        test_stall();
        test_reset_flight();
        test_back_to_back();
`ifdef WILDCMP_HIT_CNT_EN
        test_hit_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
